registerfile_param: RTL and testbench
=====================================

// Module: registerfile_param
// PURPOSE
//  Parametrised MIPS-style register file, successor to the fixed 32x32 file.
//  2 async read ports (rs/rt), 1 sync write port (rd), optional hard-wired zero register.
//  Adds a sequenced bulk-clear engine (one register per cycle, busy flag).
//  Sits in the CPU decode stage and feeds ALU operands A/B.
//  Write-back data returns on inBack.
// PARAMETERS
//  DATA_W    32  register width in bits
//  ADDR_W    5   register address width; DEPTH = 2**ADDR_W (localparam)
//  ZERO_REG  1   1: register 0 reads 0 and ignores writes; 0: register 0 is ordinary
// PORTS
//  Clk     in   1       clock; all state updates on rising edge
//  Reset   in   1       asynchronous, active-low reset
//  we      in   1       write enable for rd/inBack
//  rd      in   ADDR_W  write address
//  inBack  in   DATA_W  write-back data
//  rs      in   ADDR_W  read address, port A
//  rt      in   ADDR_W  read address, port B
//  outa    out  DATA_W  read data, port A (combinational)
//  outb    out  DATA_W  read data, port B (combinational)
//  clr_req in   1       start bulk clear; single-cycle pulse or level
//  busy    out  1       high while the clear sequence runs
// BEHAVIOUR
//  Reset low (async): every register = 0; FSM = IDLE; clear index = 0; busy = 0.
//  Outputs therefore read 0 during reset.
//  Write: at the rising edge, when we=1 and busy=0, reg[rd] <= inBack.
//  - rd=0 with ZERO_REG=1: write dropped.
//  - we=1 while busy=1: write dropped silently.
//  Read: outa = reg[rs] and outb = reg[rt], combinational, zero latency.
//  - rs=rt is allowed; both ports return the same value.
//  - Address 0 with ZERO_REG=1: reads 0.
//  FSM states: IDLE, CLEAR.
//  - IDLE -> CLEAR: clr_req=1 at an edge. idx <= FIRST (1 if ZERO_REG else 0); busy <= 1.
//  - CLEAR: reg[idx] <= 0 and idx <= idx+1 each cycle.
//  - CLEAR -> IDLE: on the edge that clears idx = DEPTH-1; busy <= 0 on that same edge.
//  - busy stays high for exactly DEPTH-FIRST cycles (31 for the defaults).
//  - clr_req during CLEAR is ignored; there is no re-trigger and no queueing.
//  - clr_req held high at CLEAR exit starts a new sequence on the next edge.
//  - Reads during CLEAR return current contents (cleared or not yet cleared). They are not forced to 0.
//  - A write in the same IDLE cycle as clr_req is accepted; the sequence later zeroes it.
//  - idx is ADDR_W bits wide; it must not wrap past DEPTH-1.
//  - Reset asserted mid-clear: immediate all-zero, IDLE, busy=0.
// CONFIGURATION
//  REGFILE_BYPASS_EN defined: write-to-read forwarding.
//  - Condition: we=1, busy=0, rd!=0 (or ZERO_REG=0) and rd==rs.
//  - Result: outa = inBack in that same cycle. The same rule with rt drives outb.
//  - A read in the write cycle returns the new value.
//  REGFILE_BYPASS_EN undefined: no forwarding.
//  - A read in the write cycle returns the old value; the new value is visible after the edge.
// TESTING
//  1 Reset low mid-run, rs=5,rt=31 -> outa=outb=0; busy=0 while reset held.
//  2 we=1, rd=5, inBack=32'h5F, 1 edge; then we=0, rs=5 -> outa=32'h5F.
//    rd=17, inBack=32'h06530025 -> outb=32'h06530025 with rt=17.
//  3 ZERO_REG=1: we=1, rd=0, inBack=32'hFFFFFFFF -> rs=0 gives outa=0.
//    ZERO_REG=0 build -> outa=32'hFFFFFFFF.
//  4 Fill regs 1..31 with their index.
//    Pulse clr_req -> busy high exactly 31 cycles; all reads 0 afterwards.
//    we=1, rd=3, inBack=32'h28D mid-clear -> dropped; reg3 reads 0.
//  5 rd=rs=3, inBack=32'h28D, we=1, sampled before the edge.
//    Bypass build -> outa=32'h28D; non-bypass build -> old value (0).
//  6 clr_req, then Reset low after 10 busy cycles -> busy=0 at once, all regs 0.
//    After Reset high: write rd=31, inBack=32'hFFFFFFFF -> reads back 32'hFFFFFFFF.

Source files
------------

// File: rtl/registerfile_param.sv
// ---------------------------------------------------------------------------
// registerfile_param
// Parametrised MIPS-style register file for the decode stage: two
// combinational read ports (rs/rt -> outa/outb) feeding ALU operands A/B,
// one synchronous write port (rd/inBack), an optional hard-wired zero
// register, and a sequenced bulk-clear engine that zeroes one register per
// cycle while busy is high.
//
// Optional feature macro: REGFILE_BYPASS_EN
//   defined   - write-to-read forwarding: a read of the address being written
//               in the same cycle returns inBack.
//   undefined - no forwarding: the new value is visible after the edge.
//
// Ports
//   Clk      in   1       clock, rising edge
//   Reset    in   1       asynchronous active-low reset
//   we       in   1       write enable
//   rd       in   ADDR_W  write address
//   inBack   in   DATA_W  write-back data
//   rs       in   ADDR_W  read address, port A
//   rt       in   ADDR_W  read address, port B
//   outa     out  DATA_W  read data A (combinational)
//   outb     out  DATA_W  read data B (combinational)
//   clr_req  in   1       start a bulk clear (pulse or level)
//   busy     out  1       high while the clear sequence runs (registered)
// ---------------------------------------------------------------------------
module registerfile_param #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned ZERO_REG = 1
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] rd,
    input  logic [DATA_W-1:0] inBack,
    input  logic [ADDR_W-1:0] rs,
    input  logic [ADDR_W-1:0] rt,
    output logic [DATA_W-1:0] outa,
    output logic [DATA_W-1:0] outb,
    input  logic              clr_req,
    output logic              busy
);

    localparam int unsigned       DEPTH = 2 ** ADDR_W;
    localparam bit                ZR    = (ZERO_REG != 0);
    // With a hard-wired zero register the clear sequence skips address 0.
    localparam logic [ADDR_W-1:0] FIRST = ZR ? ADDR_W'(1) : ADDR_W'(0);
    localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] idx;
    logic [ADDR_W-1:0] idx_nxt;
    logic [DATA_W-1:0] regs [DEPTH];
    logic              wr_en;
    logic [DATA_W-1:0] rd_a;
    logic [DATA_W-1:0] rd_b;

    // Clear-engine state register; busy mirrors the next state so it is a flop.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state <= IDLE;
            idx   <= '0;
            busy  <= 1'b0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
            busy  <= (state_nxt == CLEAR);
        end
    end

    // Clear-engine next state; idx stops at LAST and never wraps.
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        case (state)
            IDLE: begin
                if (clr_req) begin
                    state_nxt = CLEAR;
                    idx_nxt   = FIRST;
                end
            end
            CLEAR: begin
                if (idx == LAST) begin
                    state_nxt = IDLE;
                    idx_nxt   = '0;
                end else begin
                    idx_nxt = idx + ADDR_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                idx_nxt   = '0;
            end
        endcase
    end

    // Writes are only accepted in IDLE and never land on a hard-wired zero.
    assign wr_en = we && (state == IDLE) && !(ZR && (rd == '0));

    // Register array: async reset, clear engine has priority over writes.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                regs[ADDR_W'(i)] <= '0;
            end
        end else if (state == CLEAR) begin
            regs[idx] <= '0;
        end else if (wr_en) begin
            regs[rd] <= inBack;
        end
    end

    // Array read with zero-register masking.
    assign rd_a = (ZR && (rs == '0)) ? '0 : regs[rs];
    assign rd_b = (ZR && (rt == '0)) ? '0 : regs[rt];

`ifdef REGFILE_BYPASS_EN
    // Forward the in-flight write so a same-cycle read sees the new value.
    assign outa = (wr_en && (rd == rs)) ? inBack : rd_a;
    assign outb = (wr_en && (rd == rt)) ? inBack : rd_b;
`else
    assign outa = rd_a;
    assign outb = rd_b;
`endif

endmodule

// File: tb/tb_registerfile_param.sv
// ---------------------------------------------------------------------------
// tb_registerfile_param
// Directed bench for registerfile_param. Two instances share all inputs: the
// default build (ZERO_REG=1) and an ordinary-register-0 build (ZERO_REG=0).
// ---------------------------------------------------------------------------
module tb_registerfile_param;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 5;

    logic              Clk;
    logic              Reset;
    logic              we;
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] inBack;
    logic [ADDR_W-1:0] rs;
    logic [ADDR_W-1:0] rt;
    logic              clr_req;
    logic [DATA_W-1:0] outa;
    logic [DATA_W-1:0] outb;
    logic              busy;
    logic [DATA_W-1:0] outa_nz;
    logic [DATA_W-1:0] outb_nz;
    logic              busy_nz;

    int total;
    int bad;

    registerfile_param #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .ZERO_REG(1)
    ) u_dut (
        .Clk    (Clk),
        .Reset  (Reset),
        .we     (we),
        .rd     (rd),
        .inBack (inBack),
        .rs     (rs),
        .rt     (rt),
        .outa   (outa),
        .outb   (outb),
        .clr_req(clr_req),
        .busy   (busy)
    );

    registerfile_param #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .ZERO_REG(0)
    ) u_dut_nz (
        .Clk    (Clk),
        .Reset  (Reset),
        .we     (we),
        .rd     (rd),
        .inBack (inBack),
        .rs     (rs),
        .rt     (rt),
        .outa   (outa_nz),
        .outb   (outb_nz),
        .clr_req(clr_req),
        .busy   (busy_nz)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // One write cycle; inputs change 1 time unit after the edge.
    task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        we     = 1'b1;
        rd     = a;
        inBack = d;
        @(posedge Clk);
        #1;
        we = 1'b0;
    endtask

    task automatic test_reset;
        Reset   = 1'b0;
        we      = 1'b0;
        rd      = '0;
        inBack  = '0;
        rs      = 5'd5;
        rt      = 5'd31;
        clr_req = 1'b0;
        #1;
        total++;
        if (outa !== 32'h0) begin
            bad++;
            $display("FAIL reset_outa: got %h want %h", outa, 32'h0);
        end
        total++;
        if (outb !== 32'h0) begin
            bad++;
            $display("FAIL reset_outb: got %h want %h", outb, 32'h0);
        end
        total++;
        if (busy !== 1'b0 || busy_nz !== 1'b0) begin
            bad++;
            $display("FAIL reset_busy: got %b/%b want 0/0", busy, busy_nz);
        end
        repeat (2) @(posedge Clk);
        #1;
        Reset = 1'b1;
        @(posedge Clk);
        #1;
    endtask

    task automatic test_write;
        do_write(5'd5, 32'h5F);
        do_write(5'd17, 32'h06530025);
        rs = 5'd5;
        rt = 5'd17;
        #1;
        total++;
        if (outa !== 32'h5F) begin
            bad++;
            $display("FAIL write_r5: got %h want %h", outa, 32'h5F);
        end
        total++;
        if (outb !== 32'h06530025) begin
            bad++;
            $display("FAIL write_r17: got %h want %h", outb, 32'h06530025);
        end
        rt = 5'd5;
        #1;
        total++;
        if (outa !== 32'h5F || outb !== 32'h5F) begin
            bad++;
            $display("FAIL same_addr: got %h/%h want %h/%h", outa, outb, 32'h5F, 32'h5F);
        end
    endtask

    task automatic test_reset_midrun;
        rs = 5'd5;
        rt = 5'd31;
        do_write(5'd31, 32'h1234_5678);
        Reset = 1'b0;
        #1;
        total++;
        if (outa !== 32'h0 || outb !== 32'h0) begin
            bad++;
            $display("FAIL midrun_reset_data: got %h/%h want 0/0", outa, outb);
        end
        @(posedge Clk);
        #1;
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL midrun_reset_busy: got %b want 0", busy);
        end
        Reset = 1'b1;
        @(posedge Clk);
        #1;
    endtask

    task automatic test_zero_reg;
        do_write(5'd0, 32'hFFFF_FFFF);
        rs = 5'd0;
        rt = 5'd0;
        #1;
        total++;
        if (outa !== 32'h0 || outb !== 32'h0) begin
            bad++;
            $display("FAIL zero_reg_on: got %h/%h want 0/0", outa, outb);
        end
        total++;
        if (outa_nz !== 32'hFFFF_FFFF) begin
            bad++;
            $display("FAIL zero_reg_off: got %h want %h", outa_nz, 32'hFFFF_FFFF);
        end
    endtask

    task automatic test_clear;
        int cnt;
        int cnt_nz;
        for (int a = 1; a < 32; a++) begin
            do_write(ADDR_W'(a), DATA_W'(a));
        end
        rs = 5'd7;
        rt = 5'd31;
        #1;
        total++;
        if (outa !== 32'd7 || outb !== 32'd31) begin
            bad++;
            $display("FAIL fill: got %h/%h want %h/%h", outa, outb, 32'd7, 32'd31);
        end
        clr_req = 1'b1;
        @(posedge Clk);
        #1;
        clr_req = 1'b0;
        cnt     = 0;
        cnt_nz  = 0;
        for (int c = 0; c < 100; c++) begin
            if (busy === 1'b1) cnt++;
            if (busy_nz === 1'b1) cnt_nz++;
            if (busy !== 1'b1 && busy_nz !== 1'b1) break;
            if (c == 5) begin
                // reg3 is already cleared; this write must be dropped
                we     = 1'b1;
                rd     = 5'd3;
                inBack = 32'h28D;
                rt     = 5'd20;
                #1;
                total++;
                if (outb !== 32'd20) begin
                    bad++;
                    $display("FAIL read_during_clear: got %h want %h", outb, 32'd20);
                end
            end else begin
                we = 1'b0;
            end
            @(posedge Clk);
            #1;
        end
        we = 1'b0;
        total++;
        if (cnt != 31) begin
            bad++;
            $display("FAIL busy_len: got %0d want %0d", cnt, 31);
        end
        total++;
        if (cnt_nz != 32) begin
            bad++;
            $display("FAIL busy_len_nz: got %0d want %0d", cnt_nz, 32);
        end
        for (int a = 0; a < 32; a++) begin
            rs = ADDR_W'(a);
            rt = ADDR_W'(a);
            #1;
            total++;
            if (outa !== 32'h0 || outb !== 32'h0 || outa_nz !== 32'h0) begin
                bad++;
                $display("FAIL cleared_r%0d: got %h/%h/%h want 0", a, outa, outb, outa_nz);
            end
        end
    endtask

    task automatic test_bypass;
        logic [DATA_W-1:0] exp_same;
`ifdef REGFILE_BYPASS_EN
        exp_same = 32'h28D;
`else
        exp_same = 32'h0;
`endif
        we     = 1'b1;
        rd     = 5'd3;
        rs     = 5'd3;
        rt     = 5'd3;
        inBack = 32'h28D;
        #1;
        total++;
        if (outa !== exp_same || outb !== exp_same) begin
            bad++;
            $display("FAIL same_cycle_read: got %h/%h want %h", outa, outb, exp_same);
        end
        @(posedge Clk);
        #1;
        we = 1'b0;
        #1;
        total++;
        if (outa !== 32'h28D) begin
            bad++;
            $display("FAIL after_edge_read: got %h want %h", outa, 32'h28D);
        end
    endtask

    task automatic test_reset_midclear;
        do_write(5'd20, 32'hABCD);
        clr_req = 1'b1;
        @(posedge Clk);
        #1;
        clr_req = 1'b0;
        repeat (10) @(posedge Clk);
        #1;
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL busy_midclear: got %b want 1", busy);
        end
        Reset = 1'b0;
        rs    = 5'd20;
        rt    = 5'd31;
        #1;
        total++;
        if (busy !== 1'b0 || busy_nz !== 1'b0) begin
            bad++;
            $display("FAIL reset_midclear_busy: got %b/%b want 0/0", busy, busy_nz);
        end
        total++;
        if (outa !== 32'h0 || outb !== 32'h28D - 32'h28D) begin
            bad++;
            $display("FAIL reset_midclear_data: got %h/%h want 0/0", outa, outb);
        end
        #2;
        Reset = 1'b1;
        @(posedge Clk);
        #1;
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL busy_after_reset: got %b want 0", busy);
        end
        do_write(5'd31, 32'hFFFF_FFFF);
        rs = 5'd31;
        #1;
        total++;
        if (outa !== 32'hFFFF_FFFF) begin
            bad++;
            $display("FAIL post_reset_write: got %h want %h", outa, 32'hFFFF_FFFF);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset;
        test_write;
        test_reset_midrun;
        test_zero_reg;
        test_clear;
        test_bypass;
        test_reset_midclear;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard stop in case a wait never returns.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
